decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
- Parametrised decode stage for the pipelined CPU.
- Holds the register file with same-cycle write bypass and resolves branches in decode.
- Detects load-use hazards, generates a one-cycle stall plus bubble, and registers decoded operands into the D/E pipeline register feeding execute.
- Generalises the earlier fixed 16-bit/16-register decode stage in data width, register count and PC width, and adds stall/flush/valid handling.

Parameters:
- DATA_W, 16, operand/register data width.
- REG_AW, 4, register address width; register count = 2**REG_AW.
- PC_W, 12, program counter width.
- INST_W, 4+3*REG_AW, instruction width. Field layout: [INST_W-1:3*REG_AW] opcode; then rs1, rs2, rd fields of REG_AW bits each, MSB to LSB.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_d  in  INST_W  instruction in decode.
- valid_d  in  1  inst_d is a real instruction.
- pc_d  in  PC_W  PC of inst_d.
- branch_d  in  1  inst_d is a branch-if-equal.
- imm_d  in  1  operand 2 = zero-extended rs2 field instead of register.
- load_d  in  1  inst_d is a memory load.
- stall_in  in  1  downstream stall; hold D/E register.
- flush_in  in  1  squash inst_d (bubble into E).
- write_en  in  1  writeback enable.
- dest_add_w  in  REG_AW  writeback address.
- write_data  in  DATA_W  writeback data.
- hazard_stall  out  1  combinational; freeze PC and F/D.
- branch_taken  out  1  combinational branch decision.
- pc_branch  out  PC_W  combinational branch target.
- valid_e  out  1  registered; E-stage instruction valid.
- load_e  out  1  registered load flag.
- dest_add_e  out  REG_AW  registered rd.
- src_data_e1  out  DATA_W  registered operand 1.
- src_data_e2  out  DATA_W  registered operand 2.

Behaviour:
- Reset (synchronous, active-high): all 2**REG_AW registers cleared to 0. valid_e=0, load_e=0, dest_add_e=0, src_data_e1=0, src_data_e2=0. Combinational outputs then follow inputs.
- Register file write: on a clk edge with write_en=1 and reset=0, reg[dest_add_w] <= write_data. No write when reset=1. Register 0 is writable (no hardwired zero).
- Read with bypass: rdataN = (write_en && dest_add_w==rsN) ? write_data : reg[rsN], for N=1,2.
- Operands: op1 = rdata1; op2 = imm_d ? zero-extend(rs2 field) : rdata2.
- Hazard: hazard_stall = valid_d && valid_e && load_e && (dest_add_e==rs1 || (!imm_d && dest_add_e==rs2)).
- Branch: branch_taken = valid_d && branch_d && !hazard_stall && !flush_in && (rdata1==rdata2). Compare is on bypassed register values regardless of imm_d.
- Branch target: pc_branch = pc_d + sign-extend(rd field to PC_W), modulo 2**PC_W (wraps). Driven even when branch_taken=0.
- D/E register update, priority per edge:
  1. reset.
  2. stall_in=1: hold all E outputs.
  3. hazard_stall=1 or flush_in=1 or valid_d=0: bubble; valid_e=0, load_e=0, dest_add_e=0, operands=0.
  4. Otherwise load valid_e=1, load_e=load_d, dest_add_e=rd, src_data_e1=op1, src_data_e2=op2.
- Latency: one cycle decode→E. hazard_stall lasts exactly one cycle per load-use pair, because the bubble clears valid_e. If stall_in is high during a hazard, hazard_stall persists until stall_in drops.
- Simultaneous events:
  - Write and read of the same register in one cycle returns the new data.
  - Writeback during reset is discarded.
  - Reset mid-stall clears E and ends the hazard.

Test Plan:
- Reset, then write reg3=0x1234 and reg4=0x00FF; decode rs1=3, rs2=4, rd=5, valid → next cycle valid_e=1, dest_add_e=5, src_data_e1=0x1234, src_data_e2=0x00FF.
- Bypass: write_en=1, dest_add_w=7, write_data=0xBEEF in the same cycle as decoding rs1=7 → src_data_e1=0xBEEF next cycle.
- Load-use: load with rd=2 enters E; next inst rs1=2 → hazard_stall=1 for exactly one cycle; E gets a bubble (valid_e=0), then the dependent inst loads normally. The same case with imm_d=1 and rs2=2 → no stall.
- Branch: reg1=reg2=0x0010, pc_d=0x0FF0, rd=4'hF (-1), branch_d=1 → branch_taken=1, pc_branch=0x0FEF. Set reg2=0x0011 → branch_taken=0. pc_d=0xFFF, rd=1 → pc_branch=0x000 (wrap).
- stall_in held 3 cycles while decode inputs change → E outputs unchanged. flush_in=1 → next valid_e=0, branch_taken=0.
- Assert reset during a pending hazard with registers nonzero → all E outputs 0, every register reads 0, hazard_stall=0 after reset.

Source files
------------

// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bus: fetch-side decode inputs, writeback port and D/E outputs.
// The master drives decode/writeback inputs; the slave (decode stage) drives the results.
interface decode_stage_pipe_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int PC_W   = 12,
    parameter int INST_W = 4 + 3*REG_AW
);
    logic [INST_W-1:0] inst_d;
    logic              valid_d;
    logic [PC_W-1:0]   pc_d;
    logic              branch_d;
    logic              imm_d;
    logic              load_d;
    logic              stall_in;
    logic              flush_in;
    logic              write_en;
    logic [REG_AW-1:0] dest_add_w;
    logic [DATA_W-1:0] write_data;
    logic              hazard_stall;
    logic              branch_taken;
    logic [PC_W-1:0]   pc_branch;
    logic              valid_e;
    logic              load_e;
    logic [REG_AW-1:0] dest_add_e;
    logic [DATA_W-1:0] src_data_e1;
    logic [DATA_W-1:0] src_data_e2;

    modport master (
        output inst_d, valid_d, pc_d, branch_d, imm_d, load_d, stall_in, flush_in,
               write_en, dest_add_w, write_data,
        input  hazard_stall, branch_taken, pc_branch, valid_e, load_e, dest_add_e,
               src_data_e1, src_data_e2
    );

    modport slave (
        input  inst_d, valid_d, pc_d, branch_d, imm_d, load_d, stall_in, flush_in,
               write_en, dest_add_w, write_data,
        output hazard_stall, branch_taken, pc_branch, valid_e, load_e, dest_add_e,
               src_data_e1, src_data_e2
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with write bypass, branch resolution, load-use
// hazard detection and the D/E pipeline register.
module decode_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int PC_W   = 12,
    parameter int INST_W = 4 + 3*REG_AW
) (
    input  logic               clk,
    input  logic               reset,
    decode_stage_pipe_if.slave bus
);
    localparam int N_REGS = 2**REG_AW;

    logic [DATA_W-1:0] regs [N_REGS];
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [DATA_W-1:0] rdata1, rdata2, op2;
    logic              hazard;
    logic              valid_e_q, load_e_q;
    logic [REG_AW-1:0] dest_e_q;
    logic [DATA_W-1:0] src1_e_q, src2_e_q;
    logic              unused_opcode;

    assign rs1 = bus.inst_d[3*REG_AW-1 -: REG_AW];
    assign rs2 = bus.inst_d[2*REG_AW-1 -: REG_AW];
    assign rd  = bus.inst_d[REG_AW-1:0];
    assign unused_opcode = ^bus.inst_d[INST_W-1:3*REG_AW];

    // Writeback in the same cycle is forwarded so decode never sees stale data.
    assign rdata1 = (bus.write_en && bus.dest_add_w == rs1) ? bus.write_data : regs[rs1];
    assign rdata2 = (bus.write_en && bus.dest_add_w == rs2) ? bus.write_data : regs[rs2];
    assign op2    = bus.imm_d ? {{(DATA_W-REG_AW){1'b0}}, rs2} : rdata2;

    // An immediate operand does not read rs2, so only rs1 can conflict then.
    assign hazard = bus.valid_d && valid_e_q && load_e_q &&
                    (dest_e_q == rs1 || (!bus.imm_d && dest_e_q == rs2));

    assign bus.hazard_stall = hazard;
    assign bus.branch_taken = bus.valid_d && bus.branch_d && !hazard && !bus.flush_in &&
                              (rdata1 == rdata2);
    assign bus.pc_branch    = bus.pc_d + {{(PC_W-REG_AW){rd[REG_AW-1]}}, rd};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else if (bus.write_en) begin
            regs[bus.dest_add_w] <= bus.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_e_q <= 1'b0;
            load_e_q  <= 1'b0;
            dest_e_q  <= '0;
            src1_e_q  <= '0;
            src2_e_q  <= '0;
        end else if (!bus.stall_in) begin
            if (hazard || bus.flush_in || !bus.valid_d) begin
                valid_e_q <= 1'b0;
                load_e_q  <= 1'b0;
                dest_e_q  <= '0;
                src1_e_q  <= '0;
                src2_e_q  <= '0;
            end else begin
                valid_e_q <= 1'b1;
                load_e_q  <= bus.load_d;
                dest_e_q  <= rd;
                src1_e_q  <= rdata1;
                src2_e_q  <= op2;
            end
        end
    end

    assign bus.valid_e     = valid_e_q;
    assign bus.load_e      = load_e_q;
    assign bus.dest_add_e  = dest_e_q;
    assign bus.src_data_e1 = src1_e_q;
    assign bus.src_data_e2 = src2_e_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: a behavioural model checked every cycle
// plus literal expectations at the interesting points of each scenario.
module tb_decode_stage_pipe;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_en   = 1'b0;

    always #5 clk = ~clk;

    decode_stage_pipe_if bus ();

    decode_stage_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Architectural model: register array and the instruction currently in E.
    logic [15:0] m_regs [16];
    logic        m_valid, m_load;
    logic [3:0]  m_dest;
    logic [15:0] m_op1, m_op2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] mk(input logic [3:0] s1, input logic [3:0] s2,
                                       input logic [3:0] d);
        return {4'h0, s1, s2, d};
    endfunction

    function automatic logic [3:0] f_rs1(); return bus.inst_d[11:8]; endfunction
    function automatic logic [3:0] f_rs2(); return bus.inst_d[7:4];  endfunction
    function automatic logic [3:0] f_rd();  return bus.inst_d[3:0];  endfunction

    function automatic logic [15:0] m_read(input logic [3:0] a);
        if (bus.write_en && bus.dest_add_w == a) return bus.write_data;
        return m_regs[a];
    endfunction

    function automatic logic m_hazard();
        return bus.valid_d && m_valid && m_load &&
               (m_dest == f_rs1() || (!bus.imm_d && m_dest == f_rs2()));
    endfunction

    function automatic logic m_taken();
        return bus.valid_d && bus.branch_d && !m_hazard() && !bus.flush_in &&
               (m_read(f_rs1()) == m_read(f_rs2()));
    endfunction

    function automatic logic [11:0] m_target();
        int t;
        t = int'(bus.pc_d) + int'($signed(f_rd()));
        return 12'(t % 4096 + 4096);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
            m_valid = 0; m_load = 0; m_dest = 0; m_op1 = 0; m_op2 = 0;
        end else begin
            logic [15:0] r1, o2;
            r1 = m_read(f_rs1());
            o2 = bus.imm_d ? {12'h0, f_rs2()} : m_read(f_rs2());
            if (!bus.stall_in) begin
                if (m_hazard() || bus.flush_in || !bus.valid_d) begin
                    m_valid = 0; m_load = 0; m_dest = 0; m_op1 = 0; m_op2 = 0;
                end else begin
                    m_valid = 1; m_load = bus.load_d; m_dest = f_rd(); m_op1 = r1; m_op2 = o2;
                end
            end
            if (bus.write_en) m_regs[bus.dest_add_w] = bus.write_data;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hazard_stall", 32'(bus.hazard_stall), 32'(m_hazard()));
            chk("branch_taken", 32'(bus.branch_taken), 32'(m_taken()));
            chk("pc_branch",    32'(bus.pc_branch),    32'(m_target()));
            chk("valid_e",      32'(bus.valid_e),      32'(m_valid));
            chk("load_e",       32'(bus.load_e),       32'(m_load));
            chk("dest_add_e",   32'(bus.dest_add_e),   32'(m_dest));
            chk("src_data_e1",  32'(bus.src_data_e1),  32'(m_op1));
            chk("src_data_e2",  32'(bus.src_data_e2),  32'(m_op2));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.write_en = 1; bus.dest_add_w = a; bus.write_data = d;
        cyc();
        bus.write_en = 0;
    endtask

    initial begin
        reset = 1;
        bus.inst_d = '0; bus.valid_d = 0; bus.pc_d = '0; bus.branch_d = 0;
        bus.imm_d = 0; bus.load_d = 0; bus.stall_in = 0; bus.flush_in = 0;
        bus.write_en = 0; bus.dest_add_w = '0; bus.write_data = '0;
        cyc(); cyc();
        reset = 0;
        chk("rst_valid_e", 32'(bus.valid_e), 32'h0);
        chk("rst_src1", 32'(bus.src_data_e1), 32'h0);

        // basic decode
        wr(4'd3, 16'h1234);
        wr(4'd4, 16'h00FF);
        bus.inst_d = mk(3, 4, 5); bus.valid_d = 1;
        cyc();
        chk("dec_valid_e", 32'(bus.valid_e), 32'h1);
        chk("dec_dest", 32'(bus.dest_add_e), 32'h5);
        chk("dec_src1", 32'(bus.src_data_e1), 32'h1234);
        chk("dec_src2", 32'(bus.src_data_e2), 32'h00FF);

        // bypass
        bus.write_en = 1; bus.dest_add_w = 7; bus.write_data = 16'hBEEF;
        bus.inst_d = mk(7, 0, 1);
        cyc();
        bus.write_en = 0;
        chk("bypass_src1", 32'(bus.src_data_e1), 32'hBEEF);

        // load-use on rs1
        bus.inst_d = mk(0, 0, 2); bus.load_d = 1;
        cyc();
        bus.load_d = 0; bus.inst_d = mk(2, 0, 6);
        #1 chk("lu_stall", 32'(bus.hazard_stall), 32'h1);
        cyc();
        chk("lu_bubble", 32'(bus.valid_e), 32'h0);
        chk("lu_stall_end", 32'(bus.hazard_stall), 32'h0);
        cyc();
        chk("lu_issue_valid", 32'(bus.valid_e), 32'h1);
        chk("lu_issue_dest", 32'(bus.dest_add_e), 32'h6);

        // load followed by immediate use of rs2 field: no conflict
        bus.inst_d = mk(0, 0, 2); bus.load_d = 1;
        cyc();
        bus.load_d = 0; bus.imm_d = 1; bus.inst_d = mk(0, 2, 6);
        #1 chk("imm_no_stall", 32'(bus.hazard_stall), 32'h0);
        cyc();
        chk("imm_valid", 32'(bus.valid_e), 32'h1);
        chk("imm_src2", 32'(bus.src_data_e2), 32'h2);
        bus.imm_d = 0;

        // branches
        bus.valid_d = 0;
        wr(4'd1, 16'h0010);
        wr(4'd2, 16'h0010);
        bus.valid_d = 1; bus.branch_d = 1; bus.inst_d = mk(1, 2, 4'hF); bus.pc_d = 12'hFF0;
        #1 chk("br_taken", 32'(bus.branch_taken), 32'h1);
        chk("br_target", 32'(bus.pc_branch), 32'hFEF);
        bus.write_en = 1; bus.dest_add_w = 2; bus.write_data = 16'h0011;
        #1 chk("br_bypass_not", 32'(bus.branch_taken), 32'h0);
        cyc();
        bus.write_en = 0;
        #1 chk("br_not_taken", 32'(bus.branch_taken), 32'h0);
        bus.pc_d = 12'hFFF; bus.inst_d = mk(1, 2, 1);
        #1 chk("br_wrap", 32'(bus.pc_branch), 32'h000);
        bus.branch_d = 0;

        // downstream stall holds E
        bus.inst_d = mk(3, 4, 8);
        cyc();
        bus.stall_in = 1;
        for (int k = 0; k < 3; k++) begin
            bus.inst_d = mk(4'(k), 3, 4'(9 + k));
            cyc();
            chk("stall_dest", 32'(bus.dest_add_e), 32'h8);
            chk("stall_src1", 32'(bus.src_data_e1), 32'h1234);
        end
        bus.stall_in = 0;

        // flush
        bus.flush_in = 1; bus.branch_d = 1; bus.inst_d = mk(1, 1, 3);
        #1 chk("flush_no_branch", 32'(bus.branch_taken), 32'h0);
        cyc();
        chk("flush_bubble", 32'(bus.valid_e), 32'h0);
        bus.flush_in = 0; bus.branch_d = 0;

        // reset during a held hazard, with a writeback that must be dropped
        bus.inst_d = mk(0, 0, 2); bus.load_d = 1;
        cyc();
        bus.load_d = 0; bus.inst_d = mk(2, 0, 5); bus.stall_in = 1;
        cyc();
        chk("held_stall", 32'(bus.hazard_stall), 32'h1);
        reset = 1; bus.write_en = 1; bus.dest_add_w = 5; bus.write_data = 16'hAAAA;
        cyc();
        chk("rst2_valid_e", 32'(bus.valid_e), 32'h0);
        chk("rst2_dest", 32'(bus.dest_add_e), 32'h0);
        chk("rst2_stall", 32'(bus.hazard_stall), 32'h0);
        reset = 0; bus.write_en = 0; bus.stall_in = 0;
        for (int i = 0; i < 16; i++) begin
            bus.inst_d = mk(4'(i), 4'(i), 0);
            cyc();
            chk("rst2_reg", 32'(bus.src_data_e1), 32'h0);
        end

        bus.valid_d = 0;
        cyc(); cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
